// File: rtl/crc_pkg.sv
// Shared widths, default CRC constants and packet FSM states for the
// byte-serial CRC-32 engine.
package crc_pkg;

  localparam int CRC_W  = 32;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;

  localparam logic [CRC_W-1:0] INIT_DEFAULT    = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] XOR_OUT_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [LEN_W-1:0] LEN_MAX         = '1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } pkt_state_e;

endpackage

// File: rtl/crc_in_reg.sv
// Stage-1 register: holds one packet byte with its sop/eop flags and
// releases it whenever the update stage is not stalled.
module crc_in_reg
  import crc_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              stall,
  output logic              in_ready,
  output logic              valid_q,
  output logic [BYTE_W-1:0] d_q,
  output logic              sop_q,
  output logic              eop_q,
  output logic              advance
);

  assign advance  = valid_q && !stall;
  assign in_ready = !valid_q || advance;

  // A new byte may replace the held one in the same cycle it advances.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      d_q     <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      d_q     <= in_data;
      sop_q   <= in_sop;
      eop_q   <= in_eop;
    end else if (advance) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/crc_byte_engine.sv
// Table-driven reflected CRC-32 accumulator: drives the external lookup
// table address, folds its word into the running CRC and posts per-packet results.
module crc_byte_engine
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] INIT    = INIT_DEFAULT,
  parameter logic [CRC_W-1:0] XOR_OUT = XOR_OUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [CRC_W-1:0]  tab_addr,
  input  logic [CRC_W-1:0]  tab_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_abort
);

  logic              valid_q, sop_q, eop_q, advance, stall, take;
  logic [BYTE_W-1:0] d_q;
  logic [CRC_W-1:0]  crc_q, base, crc_next;
  logic [LEN_W-1:0]  len_q, len_next;
  logic              abort_d;
  pkt_state_e        state_q, state_d;

  // Only an eop byte waiting behind an unconsumed result is held back.
  assign stall = eop_q && out_valid && !out_ready;

  crc_in_reg u_in_reg (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .stall    (stall),
    .in_ready (in_ready),
    .valid_q  (valid_q),
    .d_q      (d_q),
    .sop_q    (sop_q),
    .eop_q    (eop_q),
    .advance  (advance)
  );

  assign take     = advance && (sop_q || (state_q == ACTIVE));
  assign base     = sop_q ? INIT : crc_q;
  assign crc_next = (base >> BYTE_W) ^ tab_rdata;
  assign tab_addr = valid_q ? {{(CRC_W-BYTE_W){1'b0}}, base[BYTE_W-1:0] ^ d_q} : '0;
  assign len_next = sop_q ? LEN_W'(1) : ((len_q == LEN_MAX) ? LEN_MAX : len_q + LEN_W'(1));

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    if (advance) begin
      if (sop_q) begin
        abort_d = (state_q == ACTIVE);
        state_d = eop_q ? IDLE : ACTIVE;
      end else if ((state_q == ACTIVE) && eop_q) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      out_abort <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_abort <= abort_d;
    end
  end

  // Bytes outside a packet are consumed without touching the CRC or length.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= '0;
      len_q <= '0;
    end else if (take) begin
      crc_q <= crc_next;
      len_q <= len_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_crc   <= '0;
      out_len   <= '0;
    end else if (take && eop_q) begin
      out_valid <= 1'b1;
      out_crc   <= crc_next ^ XOR_OUT;
      out_len   <= len_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
